seq_divider: RTL and testbench

Parametrised multi-cycle restoring integer divider. It computes one quotient bit per clock and supports an optional signed mode. It reports divide-by-zero and signed overflow, and uses a start/busy/done handshake. It sits beside the ALU as the execute-stage divide unit and returns `{remainder, quotient}` in the same packed layout earlier divider consumers expect.

---
 rtl/seq_divider.sv | 180 ++++++++++++++++++
 tb/tb_seq_divider.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, start/busy/done handshake.
// Define DIVIDER_SIGNED_EN to build signed (truncating) division and overflow detection.
module seq_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic                 div_zero,
    output logic                 overflow,
    output logic [2*WIDTH-1:0]   result
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH:0]       rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic                 dz_q, dz_d;
    logic                 done_q, done_d;
    logic                 div_zero_q, div_zero_d;
    logic                 overflow_q, overflow_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    logic                 accept;
    logic                 b_zero;
    logic [WIDTH:0]       shifted;
    logic [WIDTH:0]       trial;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH-1:0]     fix_q, fix_r;
    logic                 ovf_flag;
    logic                 unused_rem_msb;

    assign accept         = (state_q == IDLE) && start;
    assign b_zero         = (b == '0);
    assign shifted        = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign trial          = shifted - {1'b0, dvs_q};
    // A kept partial remainder is always below the divisor, so its MSB is never needed.
    assign unused_rem_msb = rem_q[WIDTH];

`ifdef DIVIDER_SIGNED_EN
    logic a_neg, b_neg;
    logic qneg_q, qneg_d;
    logic rneg_q, rneg_d;
    logic ovf_q, ovf_d;

    assign a_neg  = signed_op & a[WIDTH-1];
    assign b_neg  = signed_op & b[WIDTH-1];
    assign mag_a  = a_neg ? -a : a;
    assign mag_b  = b_neg ? -b : b;
    assign qneg_d = accept ? (a_neg ^ b_neg) : qneg_q;
    assign rneg_d = accept ? a_neg : rneg_q;
    assign ovf_d  = accept ? (signed_op && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1)) : ovf_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
            ovf_q  <= ovf_d;
        end
    end

    assign fix_q    = qneg_q ? -quo_q : quo_q;
    assign fix_r    = rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    assign ovf_flag = ovf_q;
`else
    logic unused_signed_op;

    assign unused_signed_op = signed_op;
    assign mag_a    = a;
    assign mag_b    = b;
    assign fix_q    = quo_q;
    assign fix_r    = rem_q[WIDTH-1:0];
    assign ovf_flag = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = b_zero ? FIX : RUN;
            RUN:     if (cnt_q == CW'(1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != IDLE);
        done     = done_q;
        div_zero = div_zero_q;
        overflow = overflow_q;
        result   = result_q;
    end

    // On divide-by-zero the raw dividend is parked in quo_q so FIX can return it unmodified.
    always_comb begin
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        dz_d       = dz_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;
        overflow_d = overflow_q;
        result_d   = result_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d = CW'(WIDTH);
                    rem_d = '0;
                    dz_d  = b_zero;
                    quo_d = b_zero ? a : mag_a;
                    dvs_d = mag_b;
                end
            end
            RUN: begin
                rem_d = trial[WIDTH] ? shifted : trial;
                quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
                cnt_d = cnt_q - CW'(1);
            end
            FIX: begin
                done_d     = 1'b1;
                div_zero_d = dz_q;
                overflow_d = ovf_flag & ~dz_q;
                result_d   = dz_q ? {quo_q, {WIDTH{1'b1}}} : {fix_r, fix_q};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            dz_q       <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            overflow_q <= 1'b0;
            result_q   <= '0;
        end else begin
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            dz_q       <= dz_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            overflow_q <= overflow_d;
            result_q   <= result_d;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider at WIDTH = 32; expected values are hand-computed.
module tb_seq_divider;

    localparam int W = 32;

`ifdef DIVIDER_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic           signed_op = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           busy, done, div_zero, overflow;
    logic [2*W-1:0] result;

    int nchk = 0;
    int nfail = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
        .a(a), .b(b), .busy(busy), .done(done),
        .div_zero(div_zero), .overflow(overflow), .result(result)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Issues one op and returns at the negedge where done is seen (or after 100 cycles).
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                          output logic [2*W-1:0] res, output int lat, output int bcnt);
        @(negedge clk);
        a = ta; b = tb_v; signed_op = ts; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        bcnt = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            lat++;
        end
        res = result;
    endtask

    task automatic test_reset();
        @(negedge clk);
        nchk++;
        if ({busy, done, div_zero, overflow} !== 4'b0) begin
            nfail++;
            $display("FAIL reset_flags: got %b want 0000", {busy, done, div_zero, overflow});
        end
        nchk++;
        if (result !== '0) begin
            nfail++;
            $display("FAIL reset_result: got %h want 0", result);
        end
        rst = 1'b1;
    endtask

    task automatic test_unsigned();
        logic [2*W-1:0] r;
        int lat, bc;
        run_op(32'd100, 32'd7, 1'b0, r, lat, bc);
        nchk++;
        if (lat !== 33) begin nfail++; $display("FAIL u100_7_latency: got %0d want 33", lat); end
        nchk++;
        if (bc !== 33) begin nfail++; $display("FAIL u100_7_busy_cycles: got %0d want 33", bc); end
        nchk++;
        if (r !== {32'd2, 32'd14}) begin nfail++; $display("FAIL u100_7_result: got %h want %h", r, {32'd2, 32'd14}); end
        nchk++;
        if ({busy, div_zero, overflow} !== 3'b000) begin
            nfail++; $display("FAIL u100_7_flags_at_done: got %b want 000", {busy, div_zero, overflow});
        end
        @(negedge clk);
        nchk++;
        if (done !== 1'b0) begin nfail++; $display("FAIL done_one_cycle: got %b want 0", done); end
        nchk++;
        if (result !== {32'd2, 32'd14}) begin nfail++; $display("FAIL result_hold: got %h want %h", result, {32'd2, 32'd14}); end
    endtask

    task automatic test_div_zero();
        logic [2*W-1:0] r;
        int lat, bc;
        for (int m = 0; m < 2; m++) begin
            run_op(32'h1234, 32'h0, m[0], r, lat, bc);
            nchk++;
            if (lat !== 1) begin nfail++; $display("FAIL dz_latency mode=%0d: got %0d want 1", m, lat); end
            nchk++;
            if (r !== {32'h1234, 32'hFFFF_FFFF}) begin
                nfail++; $display("FAIL dz_result mode=%0d: got %h want %h", m, r, {32'h1234, 32'hFFFF_FFFF});
            end
            nchk++;
            if ({div_zero, overflow} !== 2'b10) begin
                nfail++; $display("FAIL dz_flags mode=%0d: got %b want 10", m, {div_zero, overflow});
            end
        end
    endtask

    task automatic test_signed();
        logic [2*W-1:0] r;
        int lat, bc;
        logic [2*W-1:0] exp_r;
        // -7 / 2 unsigned
        run_op(32'hFFFF_FFF9, 32'd2, 1'b0, r, lat, bc);
        nchk++;
        if (r !== {32'd1, 32'h7FFF_FFFC}) begin nfail++; $display("FAIL m7_2_unsigned: got %h want %h", r, {32'd1, 32'h7FFF_FFFC}); end
        // -7 / 2 with signed_op
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, r, lat, bc);
        exp_r = SGN ? {32'hFFFF_FFFF, 32'hFFFF_FFFD} : {32'd1, 32'h7FFF_FFFC};
        nchk++;
        if (r !== exp_r) begin nfail++; $display("FAIL m7_2_signed: got %h want %h", r, exp_r); end
        nchk++;
        if (lat !== 33) begin nfail++; $display("FAIL m7_2_signed_latency: got %0d want 33", lat); end
        // 7 / -2 with signed_op
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, r, lat, bc);
        exp_r = SGN ? {32'd1, 32'hFFFF_FFFD} : {32'd7, 32'd0};
        nchk++;
        if (r !== exp_r) begin nfail++; $display("FAIL 7_m2_signed: got %h want %h", r, exp_r); end
        // MIN / -1 with signed_op
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, r, lat, bc);
        exp_r = SGN ? {32'd0, 32'h8000_0000} : {32'h8000_0000, 32'd0};
        nchk++;
        if (r !== exp_r) begin nfail++; $display("FAIL min_m1_signed: got %h want %h", r, exp_r); end
        nchk++;
        if ({div_zero, overflow} !== {1'b0, SGN}) begin
            nfail++; $display("FAIL min_m1_flags: got %b want %b", {div_zero, overflow}, {1'b0, SGN});
        end
        // MIN / -1 unsigned never flags overflow
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, r, lat, bc);
        nchk++;
        if ({r, overflow} !== {32'h8000_0000, 32'd0, 1'b0}) begin
            nfail++; $display("FAIL min_m1_unsigned: got %h/%b want %h/0", r, overflow, {32'h8000_0000, 32'd0});
        end
    endtask

    task automatic test_boundary();
        logic [2*W-1:0] r;
        int lat, bc;
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, r, lat, bc);
        nchk++;
        if (r !== {32'd0, 32'hFFFF_FFFF}) begin nfail++; $display("FAIL max_div_1: got %h want %h", r, {32'd0, 32'hFFFF_FFFF}); end
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, r, lat, bc);
        nchk++;
        if (r !== {32'd0, 32'd1}) begin nfail++; $display("FAIL max_div_max: got %h want %h", r, {32'd0, 32'd1}); end
        run_op(32'd5, 32'd9, 1'b0, r, lat, bc);
        nchk++;
        if (r !== {32'd5, 32'd0}) begin nfail++; $display("FAIL small_div_large: got %h want %h", r, {32'd5, 32'd0}); end
    endtask

    task automatic test_ignore_start();
        int lat;
        @(negedge clk);
        a = 32'd100; b = 32'd7; signed_op = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
            start = (lat == 10);
            if (lat == 10) begin a = 32'd50; b = 32'd5; end
        end
        start = 1'b0;
        nchk++;
        if (lat !== 33) begin nfail++; $display("FAIL ignore_latency: got %0d want 33", lat); end
        nchk++;
        if (result !== {32'd2, 32'd14}) begin nfail++; $display("FAIL ignore_result: got %h want %h", result, {32'd2, 32'd14}); end
        @(negedge clk);
        nchk++;
        if (busy !== 1'b0) begin nfail++; $display("FAIL ignore_no_relaunch: busy got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [2*W-1:0] r;
        int lat, bc;
        run_op(32'd1000, 32'd33, 1'b0, r, lat, bc);
        nchk++;
        if (r !== {32'd10, 32'd30}) begin nfail++; $display("FAIL b2b_first: got %h want %h", r, {32'd10, 32'd30}); end
        a = 32'hFFFF_FFFF; b = 32'h10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (lat == 5) begin
                nchk++;
                if ({busy, result} !== {1'b1, 32'd10, 32'd30}) begin
                    nfail++; $display("FAIL b2b_hold_during_busy: got %b/%h want 1/%h", busy, result, {32'd10, 32'd30});
                end
            end
            @(negedge clk);
            lat++;
        end
        nchk++;
        if (lat !== 33) begin nfail++; $display("FAIL b2b_latency: got %0d want 33", lat); end
        nchk++;
        if (result !== {32'hF, 32'h0FFF_FFFF}) begin
            nfail++; $display("FAIL b2b_second: got %h want %h", result, {32'hF, 32'h0FFF_FFFF});
        end
    endtask

    task automatic test_reset_mid();
        logic [2*W-1:0] r;
        int lat, bc;
        int seen_done;
        @(negedge clk);
        a = 32'd100; b = 32'd7; signed_op = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        nchk++;
        if ({busy, done, div_zero, overflow} !== 4'b0) begin
            nfail++; $display("FAIL midreset_flags: got %b want 0000", {busy, done, div_zero, overflow});
        end
        nchk++;
        if (result !== '0) begin nfail++; $display("FAIL midreset_result: got %h want 0", result); end
        @(negedge clk);
        rst = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        nchk++;
        if (seen_done !== 0) begin nfail++; $display("FAIL midreset_no_done: got %0d active cycles want 0", seen_done); end
        run_op(32'd100, 32'd7, 1'b0, r, lat, bc);
        nchk++;
        if ({lat, r} !== {32'd33, 32'd2, 32'd14}) begin
            nfail++; $display("FAIL after_reset_op: got lat %0d res %h want lat 33 res %h", lat, r, {32'd2, 32'd14});
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_div_zero();
        test_signed();
        test_boundary();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
